// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, word width and the address error check for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word array with registered read; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with valid/ready request and response channels.
// Define DMEM_STATS_EN to add saturating read/write/error access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count
`endif
);

    localparam int IW = $clog2(DEPTH_WORDS);

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic              cap_write;
    logic [31:0]       cap_addr;
    logic [WORD_W-1:0] cap_wdata;
    logic              accept, commit, c_write, c_err;
    logic [31:0]       c_addr;
    logic [WORD_W-1:0] c_wdata, arr_rdata;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge, before capture.
    assign c_write = req_ready ? req_write : cap_write;
    assign c_addr  = req_ready ? req_addr  : cap_addr;
    assign c_wdata = req_ready ? req_wdata : cap_wdata;
    assign c_err   = addr_err(c_addr, DEPTH_WORDS);

    assign rsp_err   = rsp_valid && c_err;
    assign rsp_rdata = (rsp_valid && !c_err && !cap_write) ? arr_rdata : '0;

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n = (WAIT_STATES == 0) ? RESP : WAIT;
                commit  = WAIT_STATES == 0;
            end
            WAIT: if (cnt == 4'd1) begin
                state_n = RESP;
                commit  = 1'b1;
            end
            RESP: state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt       <= 4'(WAIT_STATES);
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (commit && c_write && !c_err),
        .idx   (c_addr[IW+1:2]),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (commit) begin
            if (c_err)
                err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
            else if (c_write)
                wr_count <= (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'd1;
            else
                rd_count <= (rd_count == 16'hFFFF) ? rd_count : rd_count + 16'd1;
        end
    end
`endif

endmodule
